// File: rtl/atari7800_arb_pkg.sv
// Shared types and constants for the 7800 system-bus arbiter.
package atari7800_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_ACK,
        ARB_DMA,
        ARB_RELEASE
    } arb_state_t;

    localparam logic [1:0] HALT_ENABLE_WRITES = 2'd2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Halt/grant handshake between MARIA, the CPU wrapper and the bus arbiter.
interface bus_arbiter_if;

    logic dma_req;
    logic dma_done;
    logic cpu_halted;
    logic halt_b;
    logic dma_grant;

    modport master (
        output dma_req,
        output dma_done,
        output cpu_halted,
        input  halt_b,
        input  dma_grant
    );

    modport slave (
        input  dma_req,
        input  dma_done,
        input  cpu_halted,
        output halt_b,
        output dma_grant
    );

endinterface

// File: rtl/bus_arbiter_strobe_counter.sv
// Clearable strobe counter; next_hit flags that the next enabled strobe reaches limit.
module strobe_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         next_hit
);

    logic [W-1:0] count_q;
    logic [W:0]   inc;

    assign inc      = {1'b0, count_q} + (W+1)'(1);
    assign next_hit = (inc == {1'b0, limit});
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (en && !(&count_q)) begin
            count_q <= inc[W-1:0];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// 7800 system-bus arbiter: MARIA DMA request -> CPU halt handshake -> grant -> turnaround.
module bus_arbiter
    import atari7800_arb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned TURNAROUND  = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             pclk0,
    input  logic             pclk1,
    input  logic [1:0]       ctrl_writes,
    bus_arbiter_if.slave     bus,
    input  logic             tia_rdy,
    input  logic             maria_rdy,
    output logic             cpu_rdy,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] dma_cycles,
    output logic [CNT_W-1:0] last_dma_len
);

    localparam int unsigned MaxLimit = (ACK_TIMEOUT > TURNAROUND) ? ACK_TIMEOUT : TURNAROUND;
    localparam int unsigned SW       = (MaxLimit > 0) ? $clog2(MaxLimit + 1) : 1;
    localparam logic [SW-1:0] AckLimit  = SW'(ACK_TIMEOUT);
    localparam logic [SW-1:0] TurnLimit = SW'(TURNAROUND);

    arb_state_t       state_q, state_d;
    logic             halt_b_q, halt_b_d;
    logic             grant_q, grant_d;
    logic             terr_q, terr_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, cyc_inc;
    logic [CNT_W-1:0] last_q, last_d;
    logic             en;
    logic             cnt_clr, cnt_en, cnt_hit;
    logic [SW-1:0]    cnt_limit, cnt_val;

    assign en      = (ctrl_writes == HALT_ENABLE_WRITES);
    assign cyc_inc = (pclk0 && !(&cyc_q)) ? cyc_q + CNT_W'(1) : cyc_q;

    strobe_counter #(
        .W (SW)
    ) u_strobe_counter (
        .clk      (clk_sys),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .limit    (cnt_limit),
        .count    (cnt_val),
        .next_hit (cnt_hit)
    );

    always_comb begin
        state_d   = state_q;
        halt_b_d  = halt_b_q;
        grant_d   = grant_q;
        terr_d    = terr_q;
        cyc_d     = cyc_q;
        last_d    = last_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cnt_limit = TurnLimit;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.dma_req && en) begin
                    state_d  = ARB_WAIT_ACK;
                    halt_b_d = 1'b0;
                    cnt_clr  = 1'b1;
                end
            end
            ARB_WAIT_ACK: begin
                cnt_limit = AckLimit;
                if (!bus.dma_req || !en) begin
                    state_d = ARB_RELEASE;
                    cnt_clr = 1'b1;
                end else if (ACK_TIMEOUT == 0) begin
                    state_d = ARB_DMA;
                    grant_d = 1'b1;
                    cyc_d   = '0;
                    terr_d  = 1'b1;
                end else if (pclk0) begin
                    // pclk0 outranks a coincident pclk1, so no timeout count here
                    if (bus.cpu_halted) begin
                        state_d = ARB_DMA;
                        grant_d = 1'b1;
                        cyc_d   = '0;
                    end
                end else if (pclk1) begin
                    if (cnt_hit) begin
                        state_d = ARB_DMA;
                        grant_d = 1'b1;
                        cyc_d   = '0;
                        terr_d  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ARB_DMA: begin
                cyc_d = cyc_inc;
                if (bus.dma_done || !en) begin
                    state_d = ARB_RELEASE;
                    grant_d = 1'b0;
                    last_d  = cyc_inc;
                    cnt_clr = 1'b1;
                end
            end
            ARB_RELEASE: begin
                if (bus.dma_req && en && !bus.dma_done && bus.cpu_halted) begin
                    // back-to-back burst: CPU is still halted, skip the halt_b rise
                    state_d = ARB_DMA;
                    grant_d = 1'b1;
                    cyc_d   = '0;
                end else if ((TURNAROUND == 0) || (pclk0 && cnt_hit)) begin
                    state_d  = ARB_IDLE;
                    halt_b_d = 1'b1;
                end else begin
                    cnt_en = pclk0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            halt_b_q <= 1'b1;
            grant_q  <= 1'b0;
            terr_q   <= 1'b0;
            cyc_q    <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            halt_b_q <= halt_b_d;
            grant_q  <= grant_d;
            terr_q   <= terr_d;
            cyc_q    <= cyc_d;
            last_q   <= last_d;
        end
    end

    assign bus.halt_b    = halt_b_q;
    assign bus.dma_grant = grant_q;
    assign cpu_rdy       = tia_rdy & maria_rdy;
    assign busy          = (state_q != ARB_IDLE);
    assign timeout_err   = terr_q;
    assign dma_cycles    = cyc_q;
    assign last_dma_len  = last_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, directed handshake sequences, random run vs. model.
module tb_bus_arbiter;

    localparam int ACK  = 8;
    localparam int TURN = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pclk0 = 1'b0, pclk1 = 1'b0;
    logic [1:0] ctrl_writes = 2'd0;
    logic dma_req = 1'b0, dma_done = 1'b0, cpu_halted = 1'b0;
    logic tia_rdy = 1'b1, maria_rdy = 1'b1;

    logic        cpu_rdy, busy, terr;
    logic [15:0] cyc, last;
    logic        cpu_rdy4, busy4, terr4;
    logic [3:0]  cyc4, last4;

    bus_arbiter_if bif ();
    bus_arbiter_if bif4 ();

    assign bif.dma_req     = dma_req;
    assign bif.dma_done    = dma_done;
    assign bif.cpu_halted  = cpu_halted;
    assign bif4.dma_req    = dma_req;
    assign bif4.dma_done   = dma_done;
    assign bif4.cpu_halted = cpu_halted;

    bus_arbiter #(.ACK_TIMEOUT(ACK), .TURNAROUND(TURN), .CNT_W(16)) dut (
        .clk_sys(clk), .reset(reset), .pclk0(pclk0), .pclk1(pclk1), .ctrl_writes(ctrl_writes),
        .bus(bif.slave), .tia_rdy(tia_rdy), .maria_rdy(maria_rdy), .cpu_rdy(cpu_rdy),
        .busy(busy), .timeout_err(terr), .dma_cycles(cyc), .last_dma_len(last)
    );

    bus_arbiter #(.ACK_TIMEOUT(ACK), .TURNAROUND(TURN), .CNT_W(4)) dut4 (
        .clk_sys(clk), .reset(reset), .pclk0(pclk0), .pclk1(pclk1), .ctrl_writes(ctrl_writes),
        .bus(bif4.slave), .tia_rdy(tia_rdy), .maria_rdy(maria_rdy), .cpu_rdy(cpu_rdy4),
        .busy(busy4), .timeout_err(terr4), .dma_cycles(cyc4), .last_dma_len(last4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int phase = 0;
    bit rand_pclk = 1'b0;
    bit s_p0, s_p1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance one clk_sys; s_p0/s_p1 hold the strobes the DUT just sampled.
    task automatic step();
        @(posedge clk);
        #1;
        s_p0 = pclk0;
        s_p1 = pclk1;
        if (rand_pclk) begin
            pclk0 = ($urandom % 3) == 0;
            pclk1 = !pclk0 && (($urandom % 3) == 0);
        end else begin
            phase = (phase + 1) % 4;
            pclk0 = (phase == 0);
            pclk1 = (phase == 2);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; dma_req = 1'b0; dma_done = 1'b0; cpu_halted = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        for (int i = 0; i < 64; i++) begin
            if (bif.dma_grant) break;
            step();
        end
        check(name, bif.dma_grant, 1);
    endtask

    task automatic wait_p0(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 8 * n + 8 && seen < n; i++) begin
            step();
            if (s_p0) seen++;
        end
        check(name, seen, n);
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: ownership phase kept as flags plus plain integer counts.
    bit m_halt = 0, m_grant = 0, m_terr = 0;
    int m_rel = -1, m_acks = 0, m_n = 0, m_last = 0;

    always @(posedge clk) begin
        bit en;
        en = (ctrl_writes == 2'd2);
        if (reset) begin
            m_halt = 0; m_grant = 0; m_terr = 0; m_rel = -1; m_acks = 0; m_n = 0; m_last = 0;
        end else if (!m_halt) begin
            if (dma_req && en) begin m_halt = 1; m_acks = 0; end
        end else if (m_grant) begin
            if (pclk0) m_n++;
            if (dma_done || !en) begin m_grant = 0; m_last = m_n; m_rel = TURN; end
        end else if (m_rel >= 0) begin
            if (dma_req && en && !dma_done && cpu_halted) begin
                m_grant = 1; m_rel = -1; m_n = 0;
            end else begin
                if (pclk0) m_rel--;
                if (m_rel <= 0) begin m_halt = 0; m_rel = -1; end
            end
        end else begin
            if (!dma_req || !en) m_rel = TURN;
            else if (pclk0 && cpu_halted) begin m_grant = 1; m_n = 0; end
            else if (pclk1 && !pclk0) begin
                m_acks++;
                if (m_acks >= ACK) begin m_grant = 1; m_n = 0; m_terr = 1; end
            end
        end
    end

    typedef struct {
        logic [1:0] ctrl;
        bit req, tia, maria, exp_rdy, exp_busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n1, viol;
        bit early;

        vecs[0] = '{2'd2, 1, 1, 1, 1, 1};
        vecs[1] = '{2'd2, 0, 1, 0, 0, 0};
        vecs[2] = '{2'd1, 1, 0, 1, 0, 0};
        vecs[3] = '{2'd3, 1, 1, 1, 1, 0};
        vecs[4] = '{2'd0, 1, 0, 0, 0, 0};
        vecs[5] = '{2'd2, 1, 0, 0, 0, 1};
        vecs[6] = '{2'd0, 0, 1, 1, 1, 0};
        vecs[7] = '{2'd2, 1, 1, 0, 0, 1};

        // Reset state
        do_reset();
        check("rst_halt_b", bif.halt_b, 1);
        check("rst_grant", bif.dma_grant, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", terr, 0);
        check("rst_cycles", cyc, 0);
        check("rst_last", last, 0);

        // Vector table: idle response to one clock of request
        foreach (vecs[k]) begin
            do_reset();
            ctrl_writes = vecs[k].ctrl; dma_req = vecs[k].req;
            tia_rdy = vecs[k].tia; maria_rdy = vecs[k].maria;
            #1;
            check($sformatf("vec%0d_cpu_rdy", k), cpu_rdy, vecs[k].exp_rdy);
            step();
            check($sformatf("vec%0d_busy", k), busy, vecs[k].exp_busy);
            check($sformatf("vec%0d_halt_b", k), bif.halt_b, !vecs[k].exp_busy);
        end
        tia_rdy = 1'b1; maria_rdy = 1'b1;

        // Basic handshake
        do_reset();
        ctrl_writes = 2'd2; dma_req = 1'b1; cpu_halted = 1'b0;
        step();
        check("hs_halt_b_fall", bif.halt_b, 0);
        check("hs_busy", busy, 1);
        check("hs_no_grant", bif.dma_grant, 0);
        n1 = 0;
        for (int i = 0; i < 32 && n1 < 2; i++) begin
            step();
            if (s_p1) n1++;
        end
        check("hs_grant_before_ack", bif.dma_grant, 0);
        cpu_halted = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_p0) break;
            if (bif.dma_grant) early = 1'b1;
        end
        check("hs_grant_early", early, 0);
        check("hs_grant", bif.dma_grant, 1);
        check("hs_cycles0", cyc, 0);
        wait_p0(20, "hs_p0_wait");
        check("hs_cycles20", cyc, 20);
        dma_done = 1'b1; dma_req = 1'b0;
        step();
        dma_done = 1'b0;
        check("hs_grant_drop", bif.dma_grant, 0);
        check("hs_last20", last, 20);
        check("hs_halt_b_turn", bif.halt_b, 0);
        wait_p0(1, "hs_turn_wait");
        check("hs_halt_b_rise", bif.halt_b, 1);
        check("hs_idle", busy, 0);
        check("hs_terr", terr, 0);

        // Disabled: ctrl_writes != 2 ignores requests
        do_reset();
        ctrl_writes = 2'd1; dma_req = 1'b1;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!bif.halt_b || bif.dma_grant || busy) viol++;
        end
        check("dis_violations", viol, 0);

        // Timeout: forced grant on the 8th pclk1, sticky error
        do_reset();
        ctrl_writes = 2'd2; dma_req = 1'b1; cpu_halted = 1'b0;
        step();
        n1 = 0; early = 1'b0;
        for (int i = 0; i < 80 && n1 < ACK; i++) begin
            step();
            if (s_p1) n1++;
            if (n1 < ACK && bif.dma_grant) early = 1'b1;
        end
        check("to_early", early, 0);
        check("to_strobes", n1, ACK);
        check("to_grant", bif.dma_grant, 1);
        check("to_terr", terr, 1);
        dma_done = 1'b1; dma_req = 1'b0;
        step();
        dma_done = 1'b0;
        wait_p0(1, "to_turn_wait");
        dma_req = 1'b1; cpu_halted = 1'b1;
        step();
        wait_grant("to_clean_grant");
        check("to_terr_sticky", terr, 1);
        dma_done = 1'b1; dma_req = 1'b0;
        step();
        dma_done = 1'b0;
        do_reset();
        check("to_terr_cleared", terr, 0);

        // Abort in WAIT_ACK
        do_reset();
        ctrl_writes = 2'd2; dma_req = 1'b1; cpu_halted = 1'b0;
        repeat (3) step();
        dma_req = 1'b0;
        step();
        check("ab_no_grant", bif.dma_grant, 0);
        check("ab_halt_b_low", bif.halt_b, 0);
        wait_p0(1, "ab_turn_wait");
        check("ab_halt_b_rise", bif.halt_b, 1);
        check("ab_idle", busy, 0);

        // Back-to-back re-grant from RELEASE
        do_reset();
        dma_req = 1'b1; cpu_halted = 1'b1;
        step();
        wait_grant("b2b_grant1");
        wait_p0(3, "b2b_p0_wait");
        check("b2b_cycles3", cyc, 3);
        dma_done = 1'b1; dma_req = 1'b0;
        step();
        dma_done = 1'b0;
        check("b2b_rel_grant", bif.dma_grant, 0);
        check("b2b_rel_halt_b", bif.halt_b, 0);
        dma_req = 1'b1;
        step();
        check("b2b_regrant", bif.dma_grant, 1);
        check("b2b_halt_b", bif.halt_b, 0);
        check("b2b_cycles0", cyc, 0);
        check("b2b_last3", last, 3);

        // Saturation, then reset mid-DMA
        do_reset();
        dma_req = 1'b1; cpu_halted = 1'b1;
        step();
        wait_grant("sat_grant");
        wait_p0(20, "sat_p0_wait");
        check("sat_cycles4", cyc4, 15);
        check("sat_cycles16", cyc, 20);
        reset = 1'b1; dma_req = 1'b0;
        step();
        check("mrst_halt_b", bif.halt_b, 1);
        check("mrst_grant", bif.dma_grant, 0);
        check("mrst_idle", busy, 0);
        check("mrst_cycles", cyc, 0);
        check("mrst_cycles4", cyc4, 0);
        check("mrst_last", last, 0);
        reset = 1'b0;

        // Randomized run against the model
        do_reset();
        rand_pclk = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 8 == 0) dma_req = !dma_req;
            dma_done = ($urandom % 10) == 0;
            if ($urandom % 16 == 0) cpu_halted = !cpu_halted;
            if ($urandom % 48 == 0) ctrl_writes = 2'($urandom % 4);
            else if (ctrl_writes != 2'd2 && $urandom % 4 == 0) ctrl_writes = 2'd2;
            tia_rdy = 1'($urandom); maria_rdy = 1'($urandom);
            reset = ($urandom % 400) == 0;
            step();
            check("rnd_halt_b", bif.halt_b, !m_halt);
            check("rnd_grant", bif.dma_grant, m_grant);
            check("rnd_busy", busy, m_halt);
            check("rnd_terr", terr, m_terr);
            check("rnd_cycles", cyc, sat(m_n, 16));
            check("rnd_last", last, sat(m_last, 16));
            check("rnd_cycles4", cyc4, sat(m_n, 4));
            check("rnd_last4", last4, sat(m_last, 4));
            check("rnd_grant4", bif4.dma_grant, m_grant);
            check("rnd_cpu_rdy", cpu_rdy, tia_rdy & maria_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sequences ownership of the shared 7800 system bus (AB/RW/DB) between the 6502 (Sally) and MARIA DMA.
- Converts MARIA DMA requests into a halt handshake with the CPU wrapper. Grants the bus only after the halt is acknowledged, or after a timeout.
- Runs a turnaround release back to the CPU when DMA ends.
- Sits in the Atari7800 top between maria, the CPU wrapper and ctrl_reg. Replaces the direct halt_b gating and maria_drive_AB bus select.

Parameters:
- ACK_TIMEOUT, 8: pclk1 strobes to wait for cpu_halted before forcing the grant.
- TURNAROUND, 1: pclk0 strobes that halt_b stays low after the grant drops.
- CNT_W, 16: width of the DMA cycle counters.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- pclk0  in  1  one-clk_sys CPU phase-0 strobe.
- pclk1  in  1  one-clk_sys CPU phase-1 strobe.
- ctrl_writes  in  2  ctrl_reg write count; halting is enabled only when the value is 2.
- dma_req  in  1  MARIA requests the bus (level).
- dma_done  in  1  MARIA finished the DMA burst (one-clk pulse or level).
- cpu_halted  in  1  CPU wrapper is_halted acknowledge.
- tia_rdy  in  1  TIA WSYNC ready.
- maria_rdy  in  1  MARIA ready.
- halt_b  out  1  halt request to the CPU wrapper (active-low).
- dma_grant  out  1  MARIA drives AB; top muxes AB/RW on this signal.
- cpu_rdy  out  1  combinational tia_rdy & maria_rdy.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky flag: a grant was forced without an acknowledge.
- dma_cycles  out  CNT_W  live count of pclk0 strobes in the current grant.
- last_dma_len  out  CNT_W  dma_cycles latched at the end of each grant.

Behaviour:
- Reset: state IDLE, halt_b=1, dma_grant=0, timeout_err=0, dma_cycles=0, last_dma_len=0, internal strobe counter=0. Reset can occur in any state, including mid-DMA; it returns to these values on the next clk_sys edge.
- en = (ctrl_writes == 2).
- States: IDLE, WAIT_ACK, DMA, RELEASE. All outputs except cpu_rdy and busy are registered.
- IDLE:
  - If dma_req && en: go to WAIT_ACK, halt_b<=0, clear the strobe counter.
  - If !en: dma_req is ignored.
- WAIT_ACK:
  - If cpu_halted==1 on a pclk0 strobe: go to DMA, dma_grant<=1, dma_cycles<=0. Grant latency is at least one clk_sys after halt_b falls.
  - Otherwise the strobe counter increments on each pclk1. When it reaches ACK_TIMEOUT: go to DMA with dma_grant<=1 and set timeout_err<=1.
  - If dma_req falls or en drops before the grant: go to RELEASE (abort); dma_grant stays 0.
- DMA:
  - dma_grant=1, halt_b=0. dma_cycles increments on each pclk0 and saturates at all-ones (no wrap).
  - On dma_done, or on en dropping: go to RELEASE. dma_grant<=0 on the same edge; last_dma_len<=dma_cycles, including the increment if pclk0 coincides. Clear the strobe counter.
  - dma_done and dma_req together: dma_done wins and the block goes to RELEASE.
- RELEASE:
  - halt_b stays 0 while the strobe counter counts pclk0 strobes. At TURNAROUND: halt_b<=1, go to IDLE.
  - TURNAROUND=0: exit on the first edge.
  - If dma_req && en && !dma_done while in RELEASE, and cpu_halted==1: go straight back to DMA. This is the back-to-back path: grant on the next edge, dma_cycles<=0, halt_b never rises.
- Invariant: dma_grant=1 implies halt_b=0.
- timeout_err clears only on reset.
- Simultaneous pclk0 and pclk1 never occur. If they do, the pclk0 rules take precedence.

Decomposition:
- Package atari7800_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_WAIT_ACK, ARB_DMA, ARB_RELEASE};
  - HALT_ENABLE_WRITES = 2'd2.
- One sub-module, strobe_counter: a clear/enable/terminal-count counter used for both the ack timeout and the turnaround, with width $clog2(max(ACK_TIMEOUT,TURNAROUND)+1).

Test Plan:
- Basic handshake: ctrl_writes=2, dma_req=1, cpu_halted rises 2 pclk1 strobes later → halt_b falls 1 clk after the request; dma_grant=1 after the next pclk0; 20 pclk0 strobes then dma_done → last_dma_len=20; halt_b=1 after 1 further pclk0; timeout_err=0.
- Disabled: ctrl_writes=1, dma_req=1 for 100 clk → halt_b=1, dma_grant=0, busy=0 throughout.
- Timeout: cpu_halted held 0 → dma_grant=1 exactly on the 8th pclk1 strobe; timeout_err=1 and stays 1 through later clean grants until reset.
- Abort and back-to-back:
  - dma_req drops in WAIT_ACK → no grant; halt_b returns to 1 after the turnaround.
  - dma_done then dma_req in RELEASE with cpu_halted=1 → re-grant with no halt_b rise; dma_cycles restarts at 0.
- Saturation and reset: CNT_W=4, 20 pclk0 strobes in DMA → dma_cycles=15 (held). Assert reset mid-DMA → next edge halt_b=1, dma_grant=0, state IDLE, all counters 0.
